// File: rtl/pipe_float2fixed_arbiter.sv
// Round-robin front end that shares one pipelined float32-to-fixed converter among N requesters.
// A {valid,id} tag runs alongside the converter so each result returns to the requester that issued it.
module pipe_float2fixed_arbiter #(
   parameter int N        = 4,
   parameter int WOI      = 10,
   parameter int WOF      = 10,
   parameter int PIPE_LAT = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N-1:0]              req_valid,
   input  logic [32*N-1:0]           req_data,
   output logic [N-1:0]              req_ready,
   output logic [N-1:0]              rsp_valid,
   output logic [(WOI+WOF)*N-1:0]    rsp_data,
   output logic [N-1:0]              rsp_overflow,
   output logic [31:0]               conv_in,
   input  logic [WOI+WOF-1:0]        conv_out,
   input  logic                      conv_overflow,
   output logic                      busy
);

   localparam int W  = WOI + WOF;
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] LAST_ID = PW'(N - 1);

   logic [PW-1:0]       ptr;
   logic                gnt_found;
   logic [PW-1:0]       gnt_id;
   logic [PIPE_LAT-1:0] tag_v;
   logic [PW-1:0]       tag_id [PIPE_LAT];
   logic [PW-1:0]       last_id;

   // scan ptr, ptr+1, ... modulo N; first valid wins
   always_comb begin
      int idx;
      gnt_found = 1'b0;
      gnt_id    = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = PW'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      conv_in   = 32'h0;
      if (gnt_found) begin
         req_ready[gnt_id] = 1'b1;
         conv_in           = req_data[32*int'(gnt_id) +: 32];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr   <= '0;
         tag_v <= '0;
      end else begin
         tag_v[0] <= gnt_found;
         for (int k = 1; k < PIPE_LAT; k++) tag_v[k] <= tag_v[k-1];
         if (gnt_found) ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
      end
   end

   // ids are meaningless without their valid bit, so they need no reset
   always_ff @(posedge clk) begin
      tag_id[0] <= gnt_id;
      for (int k = 1; k < PIPE_LAT; k++) tag_id[k] <= tag_id[k-1];
   end

   assign last_id = tag_id[PIPE_LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid    <= '0;
         rsp_data     <= '0;
         rsp_overflow <= '0;
      end else begin
         rsp_valid    <= '0;
         rsp_data     <= '0;
         rsp_overflow <= '0;
         if (tag_v[PIPE_LAT-1]) begin
            rsp_valid[last_id]             <= 1'b1;
            rsp_data[W*int'(last_id) +: W] <= conv_out;
            rsp_overflow[last_id]          <= conv_overflow;
         end
      end
   end

   assign busy = (|tag_v) | (|rsp_valid);

endmodule

// File: tb/tb_pipe_float2fixed_arbiter.sv
// Bench for pipe_float2fixed_arbiter: behavioural converter model, grant model and response scoreboard.
module tb_pipe_float2fixed_arbiter;
   localparam int N        = 4;
   localparam int WOI      = 10;
   localparam int WOF      = 10;
   localparam int W        = WOI + WOF;
   localparam int PIPE_LAT = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [32*N-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      rsp_valid;
   logic [W*N-1:0]    rsp_data;
   logic [N-1:0]      rsp_overflow;
   logic [31:0]       conv_in;
   logic [W-1:0]      conv_out;
   logic              conv_overflow;
   logic              busy;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   typedef struct {
      int           id;
      logic [W-1:0] data;
      logic         ovf;
      int           cyc;
   } exp_t;
   exp_t sb[$];
   int   m_ptr = 0;

   pipe_float2fixed_arbiter #(.N(N), .WOI(WOI), .WOF(WOF), .PIPE_LAT(PIPE_LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
      .conv_in(conv_in), .conv_out(conv_out), .conv_overflow(conv_overflow), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // float32 -> signed fixed WOI.WOF, round half away from zero, saturate on overflow
   function automatic logic [W:0] f2x(input logic [31:0] f);
      logic [63:0] mag;
      logic        ovf;
      int          e, sh;
      e   = int'(f[30:23]);
      sh  = e - 150 + WOF;
      mag = 64'd0;
      ovf = 1'b0;
      if (e == 255) ovf = 1'b1;
      else if (e == 0) mag = 64'd0;
      else if (sh >= 0) begin
         if (sh > W) ovf = 1'b1;
         else mag = {40'd0, 1'b1, f[22:0]} << sh;
      end else if (sh > -26)
         mag = ({40'd0, 1'b1, f[22:0]} + (64'd1 << (-sh - 1))) >> (-sh);
      if (!ovf) ovf = f[31] ? (mag > (64'd1 << (W-1))) : (mag > ((64'd1 << (W-1)) - 1));
      if (ovf) return {1'b1, f[31], {(W-1){~f[31]}}};
      return {1'b0, f[31] ? W'(~mag + 64'd1) : W'(mag)};
   endfunction

   logic [31:0] cm_in [PIPE_LAT];
   logic [W:0]  cm_res;
   always @(posedge clk) begin
      cm_in[0] <= conv_in;
      for (int k = 1; k < PIPE_LAT; k++) cm_in[k] <= cm_in[k-1];
   end
   assign cm_res        = f2x(cm_in[PIPE_LAT-1]);
   assign conv_out      = cm_res[W-1:0];
   assign conv_overflow = cm_res[W];

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // negedge monitor: busy, responses, grant/conv_in model, scoreboard push
   always @(negedge clk) begin
      logic         exp_busy;
      logic [N-1:0] exp_rdy;
      logic [W*N-1:0] ev;
      logic [31:0]  exp_cin;
      logic [W:0]   r;
      exp_t         e;
      int           g, idx;
      exp_busy = 1'b0;
      foreach (sb[j]) if (sb[j].cyc < cyc) exp_busy = 1'b1;
      check("busy", busy, exp_busy);
      if (rsp_valid != '0) begin
         if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 0);
         else begin
            e  = sb.pop_front();
            ev = '0;
            ev[W*e.id +: W] = e.data;
            check("rsp_valid", rsp_valid, N'(1) << e.id);
            check("rsp_data", rsp_data, ev);
            check("rsp_overflow", rsp_overflow, N'(e.ovf) << e.id);
            check("rsp_latency", cyc, e.cyc + PIPE_LAT + 1);
         end
      end
      if (rst) begin
         sb.delete();
         m_ptr = 0;
      end else begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
         end
         exp_rdy = (g >= 0) ? N'(1) << g : '0;
         exp_cin = (g >= 0) ? req_data[32*g +: 32] : 32'h0;
         check("req_ready", req_ready, exp_rdy);
         check("conv_in", conv_in, exp_cin);
         if (g >= 0) begin
            r = f2x(exp_cin);
            sb.push_back('{id: g, data: r[W-1:0], ovf: r[W], cyc: cyc});
            m_ptr = (g + 1) % N;
         end
      end
   end

   task automatic issue_one(input int id, input logic [31:0] f);
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_data[32*id +: 32] = f;
      step();
      req_valid = '0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (lat < 4*PIPE_LAT + 8) begin
         @(negedge clk);
         lat++;
         if (rsp_valid != '0) break;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, hs, budget;
      rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      repeat (3) step();
      rst = 1'b0;
      #1;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_data", rsp_data, 0);
      check("reset_busy", busy, 0);
      step();

      issue_one(2, 32'hc36f0d77);
      wait_rsp(lat);
      check("t1_latency", lat, PIPE_LAT + 1);
      check("t1_valid", rsp_valid, 4'b0100);
      check("t1_data", rsp_data[2*W +: W], 20'hC43CA);
      check("t1_ovf", rsp_overflow, 0);
      step();
      issue_one(2, 32'h407e7564);
      wait_rsp(lat);
      check("t1b_data", rsp_data[2*W +: W], 20'h00FE7);
      step();
      issue_one(1, 32'h44696e31);
      wait_rsp(lat);
      check("t2_ovf", rsp_overflow, 4'b0010);
      step();
      issue_one(3, 32'h80000000);
      wait_rsp(lat);
      check("t2_negzero_valid", rsp_valid, 4'b1000);
      check("t2_negzero_data", rsp_data[3*W +: W], 0);
      check("t2_negzero_ovf", rsp_overflow, 0);
      repeat (2) step();

      // full contention: pointer is back at 0 after grants 2,2,1,3
      for (int k = 0; k < 16; k++) begin
         req_valid = '1;
         for (int i = 0; i < N; i++)
            req_data[32*i +: 32] = {1'($urandom), 8'($urandom_range(140, 110)), 23'($urandom)};
         #1;
         check("t3_grant", req_ready, N'(1) << (k % N));
         step();
      end
      req_valid = '0;
      repeat (PIPE_LAT + 3) step();

      // sparse: move ptr to 3, then valids {0,1}
      issue_one(2, 32'h3f800000);
      req_valid = 4'b0011;
      req_data[31:0]  = 32'h40000000;
      req_data[63:32] = 32'hc0400000;
      #1;
      check("t4_wrap_grant0", req_ready, 4'b0001);
      step();
      check("t4_then_grant1", req_ready, 4'b0010);
      step();
      req_valid = '0;
      repeat (PIPE_LAT + 3) step();

      // reset mid-flight
      req_valid = '1;
      repeat (3) step();
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("t5_busy_after_rst", busy, 0);
      for (int k = 0; k < 2*PIPE_LAT; k++) begin
         check("t5_no_rsp", rsp_valid, 0);
         @(negedge clk);
      end
      step();

      // random traffic until 100 handshakes
      hs = 0;
      budget = 0;
      while (hs < 100 && budget < 2000) begin
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++)
            req_data[32*i +: 32] = {1'($urandom), 8'($urandom_range(145, 100)), 23'($urandom)};
         #1;
         if ((req_valid & req_ready) != '0) hs++;
         budget++;
         step();
      end
      check("t6_handshakes", hs, 100);
      req_valid = '0;
      repeat (PIPE_LAT + 4) step();
      check("drain_empty", sb.size(), 0);
      check("drain_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
